vga_out: RTL



---
 rtl/vga_out.sv | 119 +++++++++++
 1 files changed

// File: rtl/vga_out.sv
// Raster timing generator and registered VGA pin stage (640x480@60 Hz by default).
// Optional build macro VGA_BORDER_EN forces a white 1-pixel frame around the visible area.
module vga_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_DIV  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
    output logic [9:0]  col,
    output logic [9:0]  row,
    output logic        pix_en,
    output logic        frame_start,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hCnt_q, hCnt_d;
    logic [9:0]       vCnt_q, vCnt_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             frameStart_q, frameStart_d;
    logic             de;
    logic             onBorder;

    assign pix_en = (div_q == DIV_LAST);

    always_comb begin
        div_d  = div_q + DIV_W'(1);
        hCnt_d = hCnt_q;
        vCnt_d = vCnt_q;
        if (pix_en) begin
            div_d = '0;
            if (hCnt_q == H_LAST) begin
                hCnt_d = '0;
                vCnt_d = (vCnt_q == V_LAST) ? 10'd0 : vCnt_q + 10'd1;
            end else begin
                hCnt_d = hCnt_q + 10'd1;
            end
        end
    end

`ifdef VGA_BORDER_EN
    assign onBorder = (hCnt_q == 10'd0) || (hCnt_q == 10'(H_ACTIVE - 1)) ||
                      (vCnt_q == 10'd0) || (vCnt_q == 10'(V_ACTIVE - 1));
`else
    assign onBorder = 1'b0;
`endif

    // Pin values are decoded from the counters before they advance, so pins lag col/row by one pixel.
    always_comb begin
        de           = (hCnt_q < H_VIS) && (vCnt_q < V_VIS);
        rgb_d        = 12'h000;
        if (de) begin
            rgb_d = onBorder ? 12'hFFF : rgb_in;
        end
        hs_d         = !((hCnt_q >= HS_BEG) && (hCnt_q < HS_END));
        vs_d         = !((vCnt_q >= VS_BEG) && (vCnt_q < VS_END));
        frameStart_d = pix_en && (hCnt_q == H_LAST) && (vCnt_q == V_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            hCnt_q       <= '0;
            vCnt_q       <= '0;
            rgb_q        <= 12'h000;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            frameStart_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            hCnt_q       <= hCnt_d;
            vCnt_q       <= vCnt_d;
            frameStart_q <= frameStart_d;
            if (pix_en) begin
                rgb_q <= rgb_d;
                hs_q  <= hs_d;
                vs_q  <= vs_d;
            end
        end
    end

    assign col         = hCnt_q;
    assign row         = vCnt_q;
    assign frame_start = frameStart_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign r           = rgb_q[11:8];
    assign g           = rgb_q[7:4];
    assign b           = rgb_q[3:0];

endmodule
